// File: rtl/dup_checked_addsub_if.sv
// Handshake and result bus for the duplicated add/sub block.
// slave = the block itself, master = whoever drives transactions into it.
interface dup_checked_addsub_if #(
    parameter int W     = 8,
    parameter int CNT_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic             par;
    logic [2:0]       op;
    logic             inj;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     x;
    logic             xc;
    logic             err;
    logic [2:0]       err_code;
    logic             err_sticky;
    logic [CNT_W-1:0] err_count;
    logic             clr_err;

    modport slave (
        input  in_valid, a, b, par, op, inj, out_ready, clr_err,
        output in_ready, out_valid, x, xc, err, err_code, err_sticky, err_count
    );

    modport master (
        output in_valid, a, b, par, op, inj, out_ready, clr_err,
        input  in_ready, out_valid, x, xc, err, err_code, err_sticky, err_count
    );
endinterface

// File: rtl/dup_checked_addsub.sv
// Duplicated add/sub datapath with parity, op-code and copy-mismatch checks.
// Two-stage elastic pipeline: S1 captures inputs and checks parity/op code,
// S2 registers the primary sum plus the error code from both copies.

// One copy of the datapath: operand select, conditional negate, W+1 bit add.
// flip inverts sum bit 0 so a copy mismatch can be forced from outside.
module dup_checked_addsub_lane #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [2:0]   op,
    input  logic         flip,
    output logic [W:0]   sum
);
    logic         sel_a, sel_b;
    logic [W-1:0] ea, eb;

    assign sel_a = op[0] | op[1];
    assign sel_b = op[0] | op[2];
    assign ea    = sel_a ? a : (~a + 1'b1);
    assign eb    = sel_b ? b : (~b + 1'b1);
    assign sum   = ({1'b0, ea} + {1'b0, eb}) ^ {{W{1'b0}}, flip};
endmodule

module dup_checked_addsub #(
    parameter int W     = 8,
    parameter int CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dup_checked_addsub_if.slave  io
);
    localparam int NCOPY = 2;

    // vld_pipe[1] = S1 occupied, vld_pipe[2] = S2 occupied (drives out_valid)
    logic [2:1]             vld_pipe;
    logic                   s2_adv;

    logic [W-1:0]           s1_a, s1_b;
    logic [2:0]             s1_op;
    logic                   s1_inj, s1_par_err, s1_op_err;

    logic [NCOPY-1:0][W:0]  sum;
    logic                   mismatch;

    logic [W-1:0]           x_r;
    logic                   xc_r;
    logic [2:0]             code_r;
    logic                   sticky_r;
    logic [CNT_W-1:0]       cnt_r;
    logic                   err_hs;

    assign s2_adv      = !vld_pipe[2] | io.out_ready;
    assign io.in_ready = !vld_pipe[1] | s2_adv;

    // Copy 0 is primary; copy 1 is the checker and receives the injected fault.
    for (genvar g = 0; g < NCOPY; g++) begin : g_copy
        dup_checked_addsub_lane #(.W(W)) u_lane (
            .a    (s1_a),
            .b    (s1_b),
            .op   (s1_op),
            .flip ((g == 1) ? s1_inj : 1'b0),
            .sum  (sum[g])
        );
    end

    // Whole-word compare so an even number of differing bits is still caught.
    assign mismatch = (sum[0] != sum[1]);

    // Pipeline stages: S1 loads whenever it can accept, S2 whenever it advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe   <= '0;
            s1_a       <= '0;
            s1_b       <= '0;
            s1_op      <= '0;
            s1_inj     <= 1'b0;
            s1_par_err <= 1'b0;
            s1_op_err  <= 1'b0;
            x_r        <= '0;
            xc_r       <= 1'b0;
            code_r     <= '0;
        end else begin
            if (s2_adv) begin
                vld_pipe[2] <= vld_pipe[1];
                if (vld_pipe[1]) begin
                    x_r    <= sum[0][W-1:0];
                    xc_r   <= sum[0][W];
                    code_r <= {mismatch, s1_op_err, s1_par_err};
                end
            end
            if (io.in_ready) begin
                vld_pipe[1] <= io.in_valid;
                if (io.in_valid) begin
                    s1_a       <= io.a;
                    s1_b       <= io.b;
                    s1_op      <= io.op;
                    s1_inj     <= io.inj;
                    s1_par_err <= (io.par != ~^{io.a, io.b});
                    s1_op_err  <= !((io.op == 3'b001) || (io.op == 3'b010) || (io.op == 3'b100));
                end
            end
        end
    end

    assign err_hs = vld_pipe[2] & io.out_ready & (|code_r);

    // Error statistics: a delivered error beats a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_r <= 1'b0;
            cnt_r    <= '0;
        end else if (err_hs) begin
            sticky_r <= 1'b1;
            if (io.clr_err)
                cnt_r <= {{(CNT_W-1){1'b0}}, 1'b1};
            else if (cnt_r != {CNT_W{1'b1}})
                cnt_r <= cnt_r + 1'b1;
        end else if (io.clr_err) begin
            sticky_r <= 1'b0;
            cnt_r    <= '0;
        end
    end

    assign io.out_valid  = vld_pipe[2];
    assign io.x          = x_r;
    assign io.xc         = xc_r;
    assign io.err_code   = code_r;
    assign io.err        = |code_r;
    assign io.err_sticky = sticky_r;
    assign io.err_count  = cnt_r;
endmodule

// File: tb/tb_dup_checked_addsub.sv
// Directed bench for dup_checked_addsub (W=8, CNT_W=4).
module tb_dup_checked_addsub;
    logic clk = 1'b0;
    logic rst_n;
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    dup_checked_addsub_if #(.W(8), .CNT_W(4)) io ();

    dup_checked_addsub #(.W(8), .CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Parity bit that makes {a,b,par} carry an odd number of ones
    function automatic logic pgood(input logic [7:0] a, input logic [7:0] b);
        return ~^{a, b};
    endfunction

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                         input logic par, input logic inj);
        io.in_valid = 1'b1;
        io.a = a; io.b = b; io.op = op; io.par = par; io.inj = inj;
    endtask

    task automatic idle();
        io.in_valid = 1'b0;
        io.inj      = 1'b0;
    endtask

    // One isolated transaction with out_ready=1; checks the result two edges later
    task automatic one(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] op, input logic par, input logic inj,
                       input logic [8:0] exp_sum, input logic [2:0] exp_code, input logic exp_err);
        drive(a, b, op, par, inj);
        @(posedge clk); #1;
        idle();
        @(posedge clk); #1;
        chk({tag, "_vld"},  io.out_valid, 1);
        chk({tag, "_sum"},  {io.xc, io.x}, exp_sum);
        chk({tag, "_code"}, io.err_code, exp_code);
        chk({tag, "_err"},  io.err, exp_err);
        @(posedge clk); #1;
        chk({tag, "_drain"}, io.out_valid, 0);
    endtask

    task automatic clear();
        io.clr_err = 1'b1;
        @(posedge clk); #1;
        io.clr_err = 1'b0;
    endtask

    initial begin
        rst_n        = 1'b0;
        io.out_ready = 1'b1;
        io.clr_err   = 1'b0;
        io.a = '0; io.b = '0; io.op = 3'b001; io.par = 1'b0;
        idle();
        #12;
        chk("rst_vld",    io.out_valid, 0);
        chk("rst_rdy",    io.in_ready, 1);
        chk("rst_sum",    {io.xc, io.x}, 0);
        chk("rst_code",   io.err_code, 0);
        chk("rst_err",    io.err, 0);
        chk("rst_sticky", io.err_sticky, 0);
        chk("rst_cnt",    io.err_count, 0);

        // first transaction launched on the first edge after release
        @(negedge clk);
        rst_n = 1'b1;
        one("add",    8'd5, 8'd3, 3'b001, 1'b1, 1'b0, 9'h008, 3'b000, 1'b0);
        one("sub_b",  8'd5, 8'd3, 3'b010, 1'b1, 1'b0, 9'h102, 3'b000, 1'b0);
        one("op2hot", 8'd5, 8'd3, 3'b110, 1'b1, 1'b0, 9'h008, 3'b010, 1'b1);
        chk("op2hot_cnt",    io.err_count, 1);
        chk("op2hot_sticky", io.err_sticky, 1);
        clear();
        chk("clr_cnt",    io.err_count, 0);
        chk("clr_sticky", io.err_sticky, 0);

        one("parity",   8'd5, 8'd3, 3'b001, 1'b0, 1'b0, 9'h008, 3'b001, 1'b1);
        one("inj",      8'd5, 8'd3, 3'b001, 1'b1, 1'b1, 9'h008, 3'b100, 1'b1);
        chk("inj_cnt",    io.err_count, 2);
        chk("inj_sticky", io.err_sticky, 1);
        one("post_inj", 8'd5, 8'd3, 3'b001, 1'b1, 1'b0, 9'h008, 3'b000, 1'b0);
        one("carry",    8'hFF, 8'hFF, 3'b001, pgood(8'hFF, 8'hFF), 1'b0, 9'h1FE, 3'b000, 1'b0);
        one("neg_zero", 8'h00, 8'h80, 3'b100, pgood(8'h00, 8'h80), 1'b0, 9'h080, 3'b000, 1'b0);
        chk("clean_cnt", io.err_count, 2);

        // backpressure: w0=10+20, w1=200+100, w2=-7+9, w3=-0+255
        io.out_ready = 1'b0;
        drive(8'd10, 8'd20, 3'b001, pgood(8'd10, 8'd20), 1'b0);
        @(posedge clk); #1;
        chk("bp_rdy1", io.in_ready, 1);
        drive(8'd200, 8'd100, 3'b001, pgood(8'd200, 8'd100), 1'b0);
        @(posedge clk); #1;
        drive(8'd7, 8'd9, 3'b100, pgood(8'd7, 8'd9), 1'b0);
        chk("bp_rdy2", io.in_ready, 0);
        chk("bp_vld",  io.out_valid, 1);
        chk("bp_w0",   {io.xc, io.x}, 9'h01E);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("bp_hold_rdy", io.in_ready, 0);
            chk("bp_hold_sum", {io.xc, io.x}, 9'h01E);
            chk("bp_hold_vld", io.out_valid, 1);
        end
        @(negedge clk);
        io.out_ready = 1'b1;
        #1;
        chk("bp_rdy3", io.in_ready, 1);
        @(posedge clk); #1;
        chk("bp_w1", {io.xc, io.x}, 9'h12C);
        drive(8'd0, 8'd255, 3'b100, pgood(8'd0, 8'd255), 1'b0);
        @(posedge clk); #1;
        chk("bp_w2", {io.xc, io.x}, 9'h102);
        idle();
        @(posedge clk); #1;
        chk("bp_w3",     {io.xc, io.x}, 9'h0FF);
        chk("bp_w3_vld", io.out_valid, 1);
        @(posedge clk); #1;
        chk("bp_empty", io.out_valid, 0);
        chk("bp_cnt",   io.err_count, 2);

        // saturation: 15 op-code errors reach 15, a 16th holds there
        clear();
        drive(8'd9, 8'd9, 3'b000, pgood(8'd9, 8'd9), 1'b0);
        repeat (15) @(posedge clk);
        #1;
        idle();
        repeat (3) @(posedge clk);
        #1;
        chk("sat_cnt15", io.err_count, 15);
        one("sat_more", 8'd9, 8'd9, 3'b000, pgood(8'd9, 8'd9), 1'b0, 9'h1EE, 3'b010, 1'b1);
        chk("sat_hold",   io.err_count, 15);
        chk("sat_sticky", io.err_sticky, 1);

        // clear coinciding with an erroneous output handshake
        drive(8'd5, 8'd3, 3'b001, 1'b0, 1'b0);
        @(posedge clk); #1;
        idle();
        @(posedge clk); #1;
        chk("clrerr_err", io.err, 1);
        io.clr_err = 1'b1;
        @(posedge clk); #1;
        io.clr_err = 1'b0;
        chk("clrerr_cnt",    io.err_count, 1);
        chk("clrerr_sticky", io.err_sticky, 1);

        // reset with both stages occupied
        io.out_ready = 1'b0;
        drive(8'd5, 8'd3, 3'b001, 1'b1, 1'b0);
        @(posedge clk); #1;
        drive(8'd5, 8'd3, 3'b010, 1'b1, 1'b0);
        @(posedge clk); #1;
        idle();
        chk("mid_full", io.out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_vld",    io.out_valid, 0);
        chk("mid_rdy",    io.in_ready, 1);
        chk("mid_sum",    {io.xc, io.x}, 0);
        chk("mid_code",   io.err_code, 0);
        chk("mid_cnt",    io.err_count, 0);
        chk("mid_sticky", io.err_sticky, 0);
        io.out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("mid_after", io.out_valid, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
